// File: rtl/neuron_dot_product_16_20.sv
// Sequential multiply-accumulate for one MLP neuron.
// Takes N_INPUTS (x, w) pairs in Q2.13 and produces one Q6.13 sum with the
// bias added. Products and the running sum saturate, and a sticky flag
// records whether any clamping happened within the current dot product.
module neuron_dot_product_16_20 #(
  parameter int N_INPUTS = 4,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_w,
  input  logic [15:0] in_bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_sum,
  output logic        out_sat
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [19:0] acc_q, acc_d;
  logic               flag_q, flag_d;
  logic [19:0]        sum_q, sum_d;
  logic               sat_q, sat_d;

  logic signed [31:0] prodFull;
  logic signed [31:0] prodShift;
  logic signed [15:0] prodClamped;
  logic               prodSat;
  logic signed [19:0] accBase;
  logic signed [20:0] sum21;
  logic signed [19:0] accNext;
  logic               accSat;
  logic               firstBeat;
  logic               lastBeat;
  logic               accept;

  // A beat can only enter while no result is waiting downstream.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_sat   = sat_q;

  assign accept    = in_valid && in_ready;
  assign firstBeat = (cnt_q == '0);
  assign lastBeat  = (cnt_q == CNT_W'(N_INPUTS - 1));

  // Product datapath: Q4.26 product floored to Q2.13, then clamped to 16 bits.
  always_comb begin
    prodFull    = 32'($signed(in_x)) * 32'($signed(in_w));
    prodShift   = prodFull >>> 13;
    prodClamped = prodShift[15:0];
    prodSat     = 1'b0;
    if (prodShift > 32'sd32767) begin
      prodClamped = 16'sh7FFF;
      prodSat     = 1'b1;
    end else if (prodShift < -32'sd32768) begin
      prodClamped = 16'sh8000;
      prodSat     = 1'b1;
    end
  end

  // Accumulate datapath: the first beat starts from the bias instead of acc.
  always_comb begin
    accBase = firstBeat ? 20'($signed(in_bias)) : acc_q;
    sum21   = 21'(accBase) + 21'(prodClamped);
    accNext = sum21[19:0];
    accSat  = 1'b0;
    if (sum21 > 21'sd524287) begin
      accNext = 20'sh7FFFF;
      accSat  = 1'b1;
    end else if (sum21 < -21'sd524288) begin
      accNext = 20'sh80000;
      accSat  = 1'b1;
    end
  end

  // Next-state logic for the counter, accumulator, flag, result and handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d  = accNext;
          flag_d = (firstBeat ? 1'b0 : flag_q) | prodSat | accSat;
          if (lastBeat) begin
            cnt_d   = '0;
            sum_d   = accNext;
            sat_d   = flag_d;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State registers; reset discards any partial sum and any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_dot_product_16_20.sv
// Bench for neuron_dot_product_16_20: three instances (N=4, N=20, N=1) share
// one stimulus stream and are each compared every cycle with a reference
// model that buffers beats and computes the whole dot product at the end.
module tb_neuron_dot_product_16_20;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        outReady;
  logic [15:0] inX, inW, inBias;
  logic [2:0]  inReady, outValid, outSat;
  logic [19:0] outSum [3];

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  bit mValid [3];
  int mSum   [3];
  bit mSat   [3];
  int mBias  [3];
  int mCnt   [3];
  int bx     [3][20];
  int bw     [3][20];

  always #5 clk = ~clk;

  neuron_dot_product_16_20 #(.N_INPUTS(4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[0]),
    .in_x(inX), .in_w(inW), .in_bias(inBias), .out_valid(outValid[0]),
    .out_ready(outReady), .out_sum(outSum[0]), .out_sat(outSat[0]));

  neuron_dot_product_16_20 #(.N_INPUTS(20), .CNT_W(8)) dut20 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[1]),
    .in_x(inX), .in_w(inW), .in_bias(inBias), .out_valid(outValid[1]),
    .out_ready(outReady), .out_sum(outSum[1]), .out_sat(outSat[1]));

  neuron_dot_product_16_20 #(.N_INPUTS(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[2]),
    .in_x(inX), .in_w(inW), .in_bias(inBias), .out_valid(outValid[2]),
    .out_ready(outReady), .out_sum(outSum[2]), .out_sat(outSat[2]));

  function automatic int nOf(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 20 : 1);
  endfunction

  // Whole dot product from the buffered beats: floor-divide each product by
  // 2^13, clamp to 16 bits, add into a bias-seeded sum clamped to 20 bits.
  function automatic void refDot(input int k, output int sum, output bit sat);
    longint acc;
    int prod;
    int p;
    acc = mBias[k];
    sat = 1'b0;
    for (int i = 0; i < nOf(k); i++) begin
      prod = bx[k][i] * bw[k][i];
      p = int'($floor(real'(prod) / 8192.0));
      if (p > 32767) begin p = 32767; sat = 1'b1; end
      else if (p < -32768) begin p = -32768; sat = 1'b1; end
      acc = acc + p;
      if (acc > 524287) begin acc = 524287; sat = 1'b1; end
      else if (acc < -524288) begin acc = -524288; sat = 1'b1; end
    end
    sum = int'(acc);
  endfunction

  // Reference model: advances on the same edge as the DUTs.
  always @(posedge clk) begin
    int s;
    bit b;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        mValid[k] = 1'b0;
        mSum[k]   = 0;
        mSat[k]   = 1'b0;
        mCnt[k]   = 0;
      end else if (mValid[k]) begin
        if (outReady) mValid[k] = 1'b0;
      end else if (inValid) begin
        if (mCnt[k] == 0) mBias[k] = int'($signed(inBias));
        bx[k][mCnt[k]] = int'($signed(inX));
        bw[k][mCnt[k]] = int'($signed(inW));
        mCnt[k] = mCnt[k] + 1;
        if (mCnt[k] == nOf(k)) begin
          refDot(k, s, b);
          mSum[k]   = s;
          mSat[k]   = b;
          mValid[k] = 1'b1;
          mCnt[k]   = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s inst%0d actual=%0h required=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput("in_ready", k, int'(inReady[k]), int'(!mValid[k]));
        checkOutput("out_valid", k, int'(outValid[k]), int'(mValid[k]));
        checkOutput("out_sum", k, int'(outSum[k]), mSum[k] & 'hFFFFF);
        checkOutput("out_sat", k, int'(outSat[k]), int'(mSat[k]));
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset   = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input logic [15:0] x, input logic [15:0] w,
                               input logic [15:0] b);
    repeat (n) begin
      @(negedge clk);
      inValid = 1'b1;
      inX = x;
      inW = w;
      inBias = b;
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  function automatic logic [15:0] randWord();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic applyRandom(input int n);
    repeat (n) begin
      @(negedge clk);
      inValid = 1'b1;
      inX = randWord();
      inW = randWord();
      inBias = randWord();
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inValid = 1'b0;
    outReady = 1'b1;
    inX = '0;
    inW = '0;
    inBias = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset_valid", 0, int'(outValid[0]), 0);
    checkOutput("reset_ready", 0, int'(inReady[0]), 1);
    checkOutput("reset_sum", 0, int'(outSum[0]), 0);

    // 1.0 * 1.0 four times -> 4.0, result exactly one cycle after beat four
    doReset();
    applyStimulus(3, 16'h2000, 16'h2000, 16'h0000);
    checkOutput("t1_not_yet", 0, int'(outValid[0]), 0);
    checkOutput("t1_n1_sum", 2, int'(outSum[2]), 'h02000);
    applyStimulus(1, 16'h2000, 16'h2000, 16'h0000);
    checkOutput("t1_valid", 0, int'(outValid[0]), 1);
    checkOutput("t1_sum", 0, int'(outSum[0]), 'h08000);
    checkOutput("t1_sat", 0, int'(outSat[0]), 0);
    checkOutput("t1_model", 0, mSum[0] & 'hFFFFF, 'h08000);

    // Each product clamps to 0x7FFF
    doReset();
    applyStimulus(4, 16'h7FFF, 16'h7FFF, 16'h0000);
    checkOutput("t2_sum", 0, int'(outSum[0]), 'h1FFFC);
    checkOutput("t2_sat", 0, int'(outSat[0]), 1);
    checkOutput("t2_model", 0, mSum[0] & 'hFFFFF, 'h1FFFC);

    // Accumulator clamps in both directions over 20 beats
    doReset();
    applyStimulus(20, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    checkOutput("t3_pos_sum", 1, int'(outSum[1]), 'h7FFFF);
    checkOutput("t3_pos_sat", 1, int'(outSat[1]), 1);
    applyStimulus(20, 16'h8000, 16'h7FFF, 16'h0000);
    checkOutput("t3_neg_sum", 1, int'(outSum[1]), 'h80000);
    checkOutput("t3_neg_sat", 1, int'(outSat[1]), 1);
    checkOutput("t3_model", 1, mSum[1] & 'hFFFFF, 'h80000);

    // 0.5 * -2^-13 floors to -1 LSB per beat
    doReset();
    applyStimulus(4, 16'h1000, 16'hFFFF, 16'h0000);
    checkOutput("t4_sum", 0, int'(outSum[0]), 'hFFFFC);
    checkOutput("t4_sat", 0, int'(outSat[0]), 0);

    // Backpressure: result held, beats ignored, then released
    doReset();
    outReady = 1'b0;
    applyStimulus(4, 16'h2000, 16'h2000, 16'h0000);
    repeat (5) begin
      @(negedge clk);
      inValid = 1'b1;
      inX = randWord();
      inW = randWord();
      inBias = randWord();
      checkOutput("t5_hold_valid", 0, int'(outValid[0]), 1);
      checkOutput("t5_hold_ready", 0, int'(inReady[0]), 0);
      checkOutput("t5_hold_sum", 0, int'(outSum[0]), 'h08000);
    end
    @(negedge clk);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    inValid = 1'b0;
    checkOutput("t5_released", 0, int'(outValid[0]), 0);
    checkOutput("t5_ready", 0, int'(inReady[0]), 1);
    applyStimulus(4, 16'h2000, 16'h1000, 16'h0000);
    checkOutput("t5_next_sum", 0, int'(outSum[0]), 'h04000);
    outReady = 1'b1;

    // Reset mid dot product, then reset while a result is presented
    doReset();
    applyRandom(2);
    doReset();
    applyStimulus(4, 16'h2000, 16'h1000, 16'h0000);
    checkOutput("t6_sum", 0, int'(outSum[0]), 'h04000);
    outReady = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6_valid_cleared", 0, int'(outValid[0]), 0);
    checkOutput("t6_sum_cleared", 0, int'(outSum[0]), 0);
    outReady = 1'b1;

    // Single-beat dot product: 1.0 * 2.0 + bias
    doReset();
    applyStimulus(1, 16'h2000, 16'h4000, 16'h0100);
    checkOutput("n1_sum", 2, int'(outSum[2]), 'h04100);
    checkOutput("n1_sat", 2, int'(outSat[2]), 0);

    // Random traffic with occasional resets
    repeat (3000) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      inValid = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      inX = randWord();
      inW = randWord();
      inBias = randWord();
    end
    @(negedge clk);
    reset = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (4) @(negedge clk);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
